cla_seq_adder_ctrl: RTL and testbench
=====================================

Name: cla_seq_adder_ctrl

Overview:
Multi-cycle WIDTH-bit add/subtract unit that time-shares a single existing CLA4 slice (ports A, B, C0, Carry, Sum) across operand nibbles, LSB nibble first. The block registers the inter-nibble carry and uses a start/busy/done handshake. It sits between a requester (ALU sequencer or testbench driver) and the 4-bit carry look-ahead datapath, trading latency for area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (NIB = WIDTH/4 slice passes).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when the block is accepting (IDLE or DONE state).
sub  input  1  0 = a + b + cin; 1 = a + ~b + 1 (cin ignored). Sampled with start.
cin  input  1  carry-in for add. Sampled with start.
a  input  WIDTH  operand A. Sampled with start.
b  input  WIDTH  operand B. Sampled with start.
busy  output  1  high while nibble passes are in progress.
done  output  1  one-cycle pulse; result valid.
sum  output  WIDTH  result; held until the next completion.
cout  output  1  carry out of bit WIDTH-1.
overflow  output  1  two's-complement overflow of the effective operation.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; nibble index, carry and operand registers cleared. Reset wins over every other input, including mid-operation; an aborted operation never produces done.
- States:
  - IDLE: waits for start. start=1 -> ADD.
  - ADD: stays in ADD for exactly NIB cycles, then -> DONE.
  - DONE: lasts 1 cycle. start=1 -> ADD; otherwise -> IDLE.
- Accept (start=1 in IDLE or DONE):
  - latch a_r=a.
  - latch b_r = sub ? ~b : b.
  - carry_r = sub ? 1 : cin.
  - idx=0; clear the working sum register.
- ADD cycle k (k = 0..NIB-1):
  - CLA4 is driven with A=a_r[4k+3:4k], B=b_r[4k+3:4k], C0=carry_r.
  - On the edge: working sum nibble k <= CLA4 Sum; carry_r <= CLA4 Carry; idx <= idx+1.
  - After idx=NIB-1 the state moves to DONE.
- DONE cycle:
  - sum <= working sum; cout <= carry_r.
  - overflow <= (a_r[W-1]==b_r[W-1]) && (working sum[W-1]!=a_r[W-1]), using effective (possibly inverted) B.
  - done=1 for this cycle only.
  - sum, cout and overflow are registered outputs, valid from the done cycle onward and held through later operations until the next DONE.
- Timing, with start high in cycle 0:
  - busy=1 in cycles 1..NIB.
  - done=1 and busy=0 in cycle NIB+1.
  - For WIDTH=16: busy cycles 1-4, done cycle 5.
- start while busy: ignored; operands not re-sampled; no queueing.
- start during the DONE cycle: accepted (back-to-back). The next busy begins in the following cycle; done and the new accept coexist in one cycle.
- Width rules: no truncation; cout is the true carry out of WIDTH bits. For sub, cout=1 means no borrow (a >= b unsigned).
- busy and done are never high in the same cycle.

Test Plan:
- Add: a=0x1234, b=0x4321, sub=0, cin=0, start pulsed in cycle 0 -> busy cycles 1-4, done cycle 5, sum=0x5555, cout=0, overflow=0.
- Full carry ripple and carry-in: 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. Then 0x0FFF+0x0000, cin=1 -> sum=0x1000, cout=0.
- Signed overflow: 0x7FFF+0x0001 -> sum=0x8000, cout=0, overflow=1. Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, overflow=0. Subtract: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, overflow=1.
- Handshake:
  - start 0x0001+0x0001 in cycle 0; start again in cycle 2 with 0x00FF+0x0001 -> ignored, done cycle 5 with sum=0x0002.
  - Start 0x00FF+0x0001 during the done cycle 5 -> busy cycles 6-9, done cycle 10, sum=0x0100; sum holds 0x0002 through cycles 6-9.
- Reset mid-op: start in cycle 0, rst=1 in cycle 2 -> cycle 3 shows busy=0, done=0, sum=0, cout=0, overflow=0, and no done ever appears for that operation. A new start in cycle 4 completes normally with done in cycle 9.
- Parameter check: WIDTH=4 with a=0x9, b=0x8 -> busy only cycle 1, done cycle 2, sum=0x1, cout=1, overflow=1.

Source files
------------

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one 4-bit carry look-ahead slice,
// one nibble per cycle (LSB first), behind a start/busy/done handshake.

module cla4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    output logic       Carry,
    output logic [3:0] Sum
);
    logic [3:0] p, g;
    logic [4:0] c;

    assign p    = A ^ B;
    assign g    = A & B;
    assign c[0] = C0;
    assign c[1] = g[0] | (p[0] & C0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & C0);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & C0);
    assign Sum   = p ^ c[3:0];
    assign Carry = c[4];
endmodule

module cla_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  a_r, b_r, work, work_nxt;
    logic              carry_r;
    logic [3:0]        slice_a, slice_b, slice_s;
    logic              slice_c;
    logic              last;

    cla4 u_cla4 (
        .A     (slice_a),
        .B     (slice_b),
        .C0    (carry_r),
        .Carry (slice_c),
        .Sum   (slice_s)
    );

    // The final edge of ADD writes the top nibble, so the outputs are loaded from
    // the merged next value to make them valid in the done cycle itself.
    always_comb begin
        slice_a  = a_r[4*idx +: 4];
        slice_b  = b_r[4*idx +: 4];
        work_nxt = work;
        work_nxt[4*idx +: 4] = slice_s;
        last     = (idx == IDXW'(NIB - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            work     <= '0;
            carry_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        idx     <= '0;
                        work    <= '0;
                        busy    <= 1'b1;
                        state   <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    work    <= work_nxt;
                    carry_r <= slice_c;
                    if (last) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= work_nxt;
                        cout     <= slice_c;
                        overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                    (work_nxt[WIDTH-1] != a_r[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Randomized bench for cla_seq_adder_ctrl: arithmetic reference model checked every
// cycle, plus literal operations from the test plan and a WIDTH=4 instance.

module tb_cla_seq_adder_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic          clk = 1'b0;
    logic          rst, start, sub, cin;
    logic [W-1:0]  a, b;
    logic          busy, done, cout, overflow;
    logic [W-1:0]  sum;

    logic          start4;
    logic [3:0]    a4, b4, sum4;
    logic          busy4, done4, cout4, ovf4;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    cla_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    cla_seq_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(1'b0), .cin(1'b0), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {cout,sum}. For subtract, cout means "no borrow".
    function automatic logic [W:0] ref_res(logic [W-1:0] x, logic [W-1:0] y, logic s, logic c);
        logic [W:0] r;
        if (s) r = {(x >= y), x - y};
        else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return r;
    endfunction

    function automatic logic ref_ovf(logic [W-1:0] x, logic [W-1:0] y, logic s, logic c);
        int sx, sy, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = s ? (sx - sy) : (sx + sy + int'(c));
        return (r > 32767) || (r < -32768);
    endfunction

    // Model: remaining busy cycles plus the pending result of the accepted operation.
    int          rem;
    logic [W:0]  pend;
    logic        pend_ovf;
    logic        exp_busy, exp_done, exp_cout, exp_ovf;
    logic [W-1:0] exp_sum;

    always @(posedge clk) begin
        if (rst) begin
            rem <= 0; exp_busy <= 0; exp_done <= 0;
            exp_sum <= '0; exp_cout <= 0; exp_ovf <= 0;
        end else if (rem != 0) begin
            rem      <= rem - 1;
            exp_busy <= (rem != 1);
            exp_done <= (rem == 1);
            if (rem == 1) begin
                exp_sum  <= pend[W-1:0];
                exp_cout <= pend[W];
                exp_ovf  <= pend_ovf;
            end
        end else begin
            exp_done <= 1'b0;
            if (start) begin
                pend     <= ref_res(a, b, sub, cin);
                pend_ovf <= ref_ovf(a, b, sub, cin);
                rem      <= NIB;
                exp_busy <= 1'b1;
            end else begin
                exp_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("sum", sum, exp_sum);
            chk("cout", cout, exp_cout);
            chk("overflow", overflow, exp_ovf);
            chk("busy_and_done", busy & done, 1'b0);
        end
    end

    // Start one op in "cycle 0" and pin busy/done timing and the literal result.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input logic c, input logic [W-1:0] es, input logic ec,
                          input logic eo, input string name);
        bit seen = 0;
        @(negedge clk);
        start = 1; a = x; b = y; sub = s; cin = c;
        for (int k = 1; k <= 12 && !seen; k++) begin
            @(negedge clk);
            start = 0;
            if (k <= NIB) chk({name, "_busy"}, busy, 1'b1);
            if (done) begin
                seen = 1;
                chk({name, "_lat"}, k, NIB + 1);
                chk({name, "_sum"}, sum, es);
                chk({name, "_cout"}, cout, ec);
                chk({name, "_ovf"}, overflow, eo);
            end
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'hFFFF;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1; start = 0; sub = 0; cin = 0; a = '0; b = '0;
        start4 = 0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_sum", sum, 16'h0);
        rst = 0;
        chk_en = 1;

        run_op(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, "add");
        run_op(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, "ripple");
        run_op(16'h0FFF, 16'h0000, 0, 1, 16'h1000, 0, 0, "cin");
        run_op(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, "sovf");
        run_op(16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, "sub_neg");
        run_op(16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1, "sub_ovf");

        // Ignored start while busy, then back-to-back start in the done cycle.
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 5) begin chk("hs_done1", done, 1); chk("hs_sum1", sum, 16'h0002); end
            if (c >= 6 && c <= 9) chk("hs_hold", sum, 16'h0002);
            if (c == 10) begin chk("hs_done2", done, 1); chk("hs_sum2", sum, 16'h0100); end
            start = (c == 0 || c == 2 || c == 5);
            sub = 0; cin = 0;
            a = (c == 0) ? 16'h0001 : 16'h00FF;
            b = 16'h0001;
        end
        @(negedge clk); start = 0;

        // Reset mid-operation, then a fresh op.
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c == 3) begin
                chk("rst_busy", busy, 0); chk("rst_done", done, 0);
                chk("rst_sum", sum, 16'h0); chk("rst_cout", cout, 0); chk("rst_ovf", overflow, 0);
            end
            if (c >= 3 && c <= 8) chk("rst_no_done", done, 0);
            if (c == 9) begin chk("rst_new_done", done, 1); chk("rst_new_sum", sum, 16'h3333); end
            rst   = (c == 2);
            start = (c == 0 || c == 4);
            a = 16'h1111; b = 16'h2222; sub = 0; cin = 0;
        end
        @(negedge clk); start = 0;

        // WIDTH=4 instance: single slice pass.
        @(negedge clk); start4 = 1; a4 = 4'h9; b4 = 4'h8;
        @(negedge clk); start4 = 0;
        chk("w4_busy1", busy4, 1); chk("w4_done1", done4, 0);
        @(negedge clk);
        chk("w4_done", done4, 1); chk("w4_busy", busy4, 0);
        chk("w4_sum", sum4, 4'h1); chk("w4_cout", cout4, 1); chk("w4_ovf", ovf4, 1);

        // Random traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 3) != 0);
            sub   = 1'($urandom);
            cin   = 1'($urandom);
            a     = pick();
            b     = pick();
        end
        @(negedge clk); rst = 0; start = 0;
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
